// File: rtl/fmc_led_pkg.sv
// ---------------------------------------------------------------------------
// fmc_led_pkg
// Shared definitions for the FMC LED shift-register driver:
//   - led_state_t   : serializer FSM states
//   - REG_*         : byte offsets of the AXI4-Lite register block words
//   - BUSY_BIT      : bit index of the busy flag in the status register
//   - cnt_width()   : width of a counter that must hold 0..n-1 (at least 1)
// ---------------------------------------------------------------------------
package fmc_led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } led_state_t;

  localparam logic [3:0] REG_PATTERN = 4'h0;
  localparam logic [3:0] REG_CTRL    = 4'h4;
  localparam logic [3:0] REG_DIV     = 4'h8;
  localparam logic [3:0] REG_STATUS  = 4'hC;

  localparam int BUSY_BIT = 0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmc_led_tick_gen.sv
// ---------------------------------------------------------------------------
// fmc_led_tick_gen
// Phase timer for the serializer. A down-counter that flags phase_end while
// it sits at zero, then reloads with div, so each phase lasts div+1 cycles.
// The FSM pulses load on every state entry so a new phase always starts
// from a full count.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   load      in   restart the phase with div
//   div       in   phase length minus one
//   phase_end out  high during the last cycle of the current phase
// ---------------------------------------------------------------------------
module fmc_led_tick_gen
  import fmc_led_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 phase_end
);

  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load || (count == '0)) begin
      count <= div;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign phase_end = (count == '0);

endmodule

// File: rtl/fmc_led_shift_driver.sv
// ---------------------------------------------------------------------------
// fmc_led_shift_driver
// Serializes an LED pattern, MSB first, into a 74HC595-style chain.
// One transfer runs at a time; one further request is buffered (last write
// wins) and started straight from DONE without an idle cycle.
// Ports:
//   ACLK         in   system clock
//   ARESETN      in   asynchronous active-low reset
//   pattern_i    in   LED pattern, bit NUM_LEDS-1 shifted first
//   update_i     in   one-cycle request strobe
//   clk_div_i    in   divider D, each serial phase lasts D+1 cycles
//   busy_o       out  transfer in progress
//   done_o       out  one-cycle pulse after the latch phase
//   led_sclk_o   out  shift clock (data taken on rising edge)
//   led_sdata_o  out  serial data
//   led_latch_o  out  storage-register latch
//   led_oe_n_o   out  active-low output enable, released after first latch
// ---------------------------------------------------------------------------
module fmc_led_shift_driver
  import fmc_led_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [NUM_LEDS-1:0]  pattern_i,
  input  logic                 update_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 led_sclk_o,
  output logic                 led_sdata_o,
  output logic                 led_latch_o,
  output logic                 led_oe_n_o
);

  localparam int CNT_W = cnt_width(NUM_LEDS);

  led_state_t           state;
  logic [NUM_LEDS-1:0]  shift_reg;
  logic [NUM_LEDS-1:0]  shift_next;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [CNT_W-1:0]     bit_cnt;

  logic                 pending;
  logic [NUM_LEDS-1:0]  pend_pattern;
  logic [DIV_WIDTH-1:0] pend_div;

  logic                 start;
  logic [NUM_LEDS-1:0]  start_pattern;
  logic [DIV_WIDTH-1:0] start_div;
  logic                 advance;
  logic                 tick_load;
  logic [DIV_WIDTH-1:0] tick_div;
  logic                 phase_end;

  // Start decision. In DONE a same-cycle update is newer than the buffered
  // request, so it takes precedence over the pending values.
  always_comb begin
    start         = 1'b0;
    start_pattern = pattern_i;
    start_div     = clk_div_i;
    if (state == IDLE) begin
      start = update_i;
    end else if (state == DONE) begin
      start = update_i | pending;
      if (!update_i) begin
        start_pattern = pend_pattern;
        start_div     = pend_div;
      end
    end

    advance   = phase_end &&
                ((state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH));
    tick_load = start | advance;
    // A starting transfer must time its first phase with the new divider,
    // not the one captured for the previous transfer.
    tick_div  = start ? start_div : div_reg;
    shift_next = shift_reg << 1;
  end

  fmc_led_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .load      (tick_load),
    .div       (tick_div),
    .phase_end (phase_end)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= IDLE;
      shift_reg    <= '0;
      div_reg      <= '0;
      bit_cnt      <= '0;
      pending      <= 1'b0;
      pend_pattern <= '0;
      pend_div     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      led_sclk_o   <= 1'b0;
      led_sdata_o  <= 1'b0;
      led_latch_o  <= 1'b0;
      led_oe_n_o   <= 1'b1;
    end else begin
      done_o <= 1'b0;

      // Buffer requests arriving mid-transfer; DONE consumes update_i itself.
      if ((state != IDLE) && (state != DONE) && update_i) begin
        pend_pattern <= pattern_i;
        pend_div     <= clk_div_i;
        pending      <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            shift_reg   <= start_pattern;
            div_reg     <= start_div;
            bit_cnt     <= CNT_W'(NUM_LEDS - 1);
            pending     <= 1'b0;
            led_sclk_o  <= 1'b0;
            led_sdata_o <= start_pattern[NUM_LEDS-1];
            busy_o      <= 1'b1;
            state       <= SHIFT_LO;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT_LO: begin
          if (phase_end) begin
            led_sclk_o <= 1'b1;
            state      <= SHIFT_HI;
          end
        end

        SHIFT_HI: begin
          if (phase_end) begin
            led_sclk_o <= 1'b0;
            if (bit_cnt == '0) begin
              led_latch_o <= 1'b1;
              state       <= LATCH;
            end else begin
              bit_cnt     <= bit_cnt - 1'b1;
              shift_reg   <= shift_next;
              // Data only moves while sclk goes low, giving full-phase
              // setup and hold around each rising edge.
              led_sdata_o <= shift_next[NUM_LEDS-1];
              state       <= SHIFT_LO;
            end
          end
        end

        LATCH: begin
          if (phase_end) begin
            led_latch_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            // Chain now holds a valid pattern; enable outputs for good.
            led_oe_n_o  <= 1'b0;
            state       <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmc_led_shift_driver.sv
// ---------------------------------------------------------------------------
// tb_fmc_led_shift_driver
// Stimulus pushes the expected transfer (pattern, divider) into a queue when
// it issues an update; a monitor models the external 74HC595 chain from the
// serial pins and checks each completed transfer against the queue head.
// ---------------------------------------------------------------------------
module tb_fmc_led_shift_driver;
  import fmc_led_pkg::*;

  localparam int N  = 8;
  localparam int DW = 16;

  logic          ACLK    = 1'b0;
  logic          ARESETN = 1'b1;
  logic [N-1:0]  pattern_i = '0;
  logic          update_i  = 1'b0;
  logic [DW-1:0] clk_div_i = '0;
  logic          busy_o, done_o, led_sclk_o, led_sdata_o, led_latch_o, led_oe_n_o;

  always #5 ACLK = ~ACLK;

  fmc_led_shift_driver #(
    .NUM_LEDS  (N),
    .DIV_WIDTH (DW)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .pattern_i   (pattern_i),
    .update_i    (update_i),
    .clk_div_i   (clk_div_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .led_sclk_o  (led_sclk_o),
    .led_sdata_o (led_sdata_o),
    .led_latch_o (led_latch_o),
    .led_oe_n_o  (led_oe_n_o)
  );

  typedef struct {
    logic [N-1:0] pattern;
    int           div;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  logic [N-1:0] chain_shift = '0;
  logic [N-1:0] chain_store = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor: chain model + scoreboard ----------------
  logic prev_sclk = 1'b0, prev_latch = 1'b0, prev_busy = 1'b0;
  int   busy_cnt = 0, hi_cnt = 0, latch_cnt = 0;

  always @(negedge ACLK) begin
    exp_t e;
    if (!ARESETN) begin
      prev_sclk  = 1'b0;
      prev_latch = 1'b0;
      prev_busy  = 1'b0;
      busy_cnt   = 0;
      hi_cnt     = 0;
      latch_cnt  = 0;
    end else begin
      if (led_latch_o) check("latch_vs_sclk", {31'b0, led_sclk_o}, 32'd0);
      if (led_sclk_o && !prev_sclk) chain_shift = {chain_shift[N-2:0], led_sdata_o};
      if (led_latch_o && !prev_latch) chain_store = chain_shift;

      if (led_sclk_o) begin
        hi_cnt++;
      end else if (prev_sclk) begin
        if (exp_q.size() > 0) check("sclk_high_len", hi_cnt, exp_q[0].div + 1);
        hi_cnt = 0;
      end
      if (led_latch_o) latch_cnt++;
      if (busy_o) busy_cnt++;

      if (done_o) begin
        done_count++;
        check("busy_in_done", {31'b0, busy_o}, 32'd0);
        check("oe_n_at_done", {31'b0, led_oe_n_o}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done_o=1 required=no transfer pending");
        end else begin
          e = exp_q.pop_front();
          check("chain_pattern", {24'b0, chain_store}, {24'b0, e.pattern});
          check("busy_len", busy_cnt, (2 * N + 1) * (e.div + 1));
          check("latch_len", latch_cnt, e.div + 1);
          $display("XFER pattern=0x%02h div=%0d chain=0x%02h busy_cycles=%0d",
                   e.pattern, e.div, chain_store, busy_cnt);
        end
        busy_cnt  = 0;
        latch_cnt = 0;
      end else if (prev_busy && !busy_o) begin
        checks++;
        errors++;
        $display("FAIL busy_fall actual=busy dropped without done required=done_o=1");
      end

      prev_sclk  = led_sclk_o;
      prev_latch = led_latch_o;
      prev_busy  = busy_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [N-1:0] pat, input logic [DW-1:0] div);
    @(posedge ACLK); #1;
    pattern_i = pat;
    clk_div_i = div;
    update_i  = 1'b1;
    @(posedge ACLK); #1;
    update_i  = 1'b0;
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge ACLK); #1;
    case (addr)
      REG_PATTERN: begin
        pattern_i = data[N-1:0];
        update_i  = 1'b1;
      end
      REG_DIV: clk_div_i = data[DW-1:0];
      default: ;
    endcase
    @(posedge ACLK); #1;
    update_i = 1'b0;
  endtask

  function automatic logic [31:0] reg_read(input logic [3:0] addr);
    logic [31:0] r;
    r = '0;
    case (addr)
      REG_PATTERN: r[N-1:0]  = pattern_i;
      REG_DIV:     r[DW-1:0] = clk_div_i;
      REG_STATUS:  r[BUSY_BIT] = busy_o;
      default: ;
    endcase
    return r;
  endfunction

  task automatic wait_done(input int target, input int max_cyc, input string name);
    int n;
    n = 0;
    while (done_count < target && n < max_cyc) begin
      @(posedge ACLK);
      n++;
    end
    #1;
    check(name, done_count, target);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int n, rises;
    logic prev;

    #2 ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #3 ARESETN = 1'b1;

    // Idle after reset: {sclk,sdata,latch,busy,done,oe_n}
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      check("reset_idle_outs",
            {26'b0, led_sclk_o, led_sdata_o, led_latch_o, busy_o, done_o, led_oe_n_o},
            32'b000001);
    end

    // 0xA5, D=0: first bit visible the cycle after update is sampled
    exp_q.push_back('{8'hA5, 0});
    issue(8'hA5, 16'd0);
    check("first_busy",  {31'b0, busy_o},      32'd1);
    check("first_sdata", {31'b0, led_sdata_o}, 32'd1);
    check("first_sclk",  {31'b0, led_sclk_o},  32'd0);
    wait_done(1, 100, "done_a5");
    check("a5_done_one_cycle", {31'b0, done_o},     32'd0);
    check("a5_idle_busy",      {31'b0, busy_o},     32'd0);
    check("a5_oe_n_low",       {31'b0, led_oe_n_o}, 32'd0);

    // 0x01, D=3: 4-cycle phases, 68 busy cycles
    exp_q.push_back('{8'h01, 3});
    issue(8'h01, 16'd3);
    wait_done(2, 200, "done_01");

    // 0x0F then 0xF0, 0x3C mid-transfer: last write wins
    exp_q.push_back('{8'h0F, 0});
    exp_q.push_back('{8'h3C, 0});
    issue(8'h0F, 16'd0);
    repeat (2) @(posedge ACLK);
    issue(8'hF0, 16'd0);
    issue(8'h3C, 16'd0);
    wait_done(3, 100, "done_0f");
    check("busy_regained", {31'b0, busy_o}, 32'd1);
    wait_done(4, 100, "done_3c");
    repeat (30) @(posedge ACLK);
    #1;
    check("done_pulse_total", done_count, 32'd4);

    // Reset in the 4th SHIFT_HI with a request pending
    exp_q.push_back('{8'h96, 1});
    issue(8'h96, 16'd1);
    issue(8'h55, 16'd0);
    n = 0; rises = 0; prev = 1'b0;
    while (rises < 4 && n < 500) begin
      @(posedge ACLK); #1;
      if (led_sclk_o && !prev) rises++;
      prev = led_sclk_o;
      n++;
    end
    check("reach_4th_hi", rises, 32'd4);
    #2 ARESETN = 1'b0;
    #1;
    check("async_reset_outs",
          {26'b0, led_sclk_o, led_sdata_o, led_latch_o, busy_o, done_o, led_oe_n_o},
          32'b000001);
    exp_q.delete();
    repeat (3) @(posedge ACLK);
    #3 ARESETN = 1'b1;
    repeat (40) @(posedge ACLK);
    #1;
    check("no_done_after_reset", done_count, 32'd4);
    check("busy_after_reset",    {31'b0, busy_o},     32'd0);
    check("oe_n_after_reset",    {31'b0, led_oe_n_o}, 32'd1);

    // Register path: DIV=0, PATTERN=0x81, poll STATUS
    reg_write(REG_DIV, 32'd0);
    exp_q.push_back('{8'h81, 0});
    reg_write(REG_PATTERN, 32'h81);
    n = 0;
    do begin
      @(posedge ACLK); #1;
      rd = reg_read(REG_STATUS);
      n++;
    end while (rd[BUSY_BIT] && n < 200);
    check("status_poll", {31'b0, rd[BUSY_BIT]}, 32'd0);
    repeat (20) @(posedge ACLK);
    #1;
    check("axi_chain", {24'b0, chain_store}, 32'h81);
    check("axi_done_total", done_count, 32'd5);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
